// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================
// morse_pkg : shared Morse constants, types and A-Z code table
// Rev 1.0
// ============================================================
package morse_pkg;

    localparam int   LETTER_W = 5;
    localparam int   MAX_SYMS = 4;
    localparam logic DOT      = 1'b0;
    localparam logic DASH     = 1'b1;

    typedef struct packed {
        logic                valid;
        logic [LETTER_W-1:0] index;
    } lookup_t;

    typedef enum logic [2:0] {
        WAIT_REL = 3'd0,
        IDLE     = 3'd1,
        MARK     = 3'd2,
        SPACE    = 3'd3,
        EMIT     = 3'd4
    } state_t;

    // sym is left-justified: first symbol in bit 3, unused low bits are zero.
    function automatic lookup_t morse_lookup(input logic [2:0] len, input logic [3:0] sym);
        lookup_t r;
        r.valid = 1'b1;
        r.index = '0;
        case ({len, sym})
            {3'd2, 4'b0100}: r.index = 5'd0;   // A
            {3'd4, 4'b1000}: r.index = 5'd1;   // B
            {3'd4, 4'b1010}: r.index = 5'd2;   // C
            {3'd3, 4'b1000}: r.index = 5'd3;   // D
            {3'd1, 4'b0000}: r.index = 5'd4;   // E
            {3'd4, 4'b0010}: r.index = 5'd5;   // F
            {3'd3, 4'b1100}: r.index = 5'd6;   // G
            {3'd4, 4'b0000}: r.index = 5'd7;   // H
            {3'd2, 4'b0000}: r.index = 5'd8;   // I
            {3'd4, 4'b0111}: r.index = 5'd9;   // J
            {3'd3, 4'b1010}: r.index = 5'd10;  // K
            {3'd4, 4'b0100}: r.index = 5'd11;  // L
            {3'd2, 4'b1100}: r.index = 5'd12;  // M
            {3'd2, 4'b1000}: r.index = 5'd13;  // N
            {3'd3, 4'b1110}: r.index = 5'd14;  // O
            {3'd4, 4'b0110}: r.index = 5'd15;  // P
            {3'd4, 4'b1101}: r.index = 5'd16;  // Q
            {3'd3, 4'b0100}: r.index = 5'd17;  // R
            {3'd3, 4'b0000}: r.index = 5'd18;  // S
            {3'd1, 4'b1000}: r.index = 5'd19;  // T
            {3'd3, 4'b0010}: r.index = 5'd20;  // U
            {3'd4, 4'b0001}: r.index = 5'd21;  // V
            {3'd3, 4'b0110}: r.index = 5'd22;  // W
            {3'd4, 4'b1001}: r.index = 5'd23;  // X
            {3'd4, 4'b1011}: r.index = 5'd24;  // Y
            {3'd4, 4'b1100}: r.index = 5'd25;  // Z
            default:         r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_decoder_if.sv
`default_nettype none
// ============================================================
// morse_decoder_if : key input and letter valid/ready output
// Rev 1.0
// ============================================================
interface morse_decoder_if;

    logic                          key_i;
    logic                          ready_i;
    logic [morse_pkg::LETTER_W-1:0] letter_o;
    logic                          valid_o;
    logic                          error_o;
    logic                          overrun_o;

    modport master (
        input  key_i, ready_i,
        output letter_o, valid_o, error_o, overrun_o
    );

    modport slave (
        output key_i, ready_i,
        input  letter_o, valid_o, error_o, overrun_o
    );

endinterface
`default_nettype wire

// File: rtl/morse_sync.sv
`default_nettype none
// ============================================================
// morse_sync : two-flop synchronizer for the raw key input
// Rev 1.0
// ============================================================
module morse_sync (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            meta     <= key_raw;
            key_sync <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================
// morse_decoder : times key marks/spaces, decodes A-Z letters
// Rev 1.0
// ============================================================
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1000,
    parameter int CNT_W       = $clog2(3*UNIT_CYCLES+1)
) (
    input  logic            clk,
    input  logic            rst,
    morse_decoder_if.master bus
);

    localparam logic [CNT_W-1:0] GAP_CNT    = CNT_W'(3*UNIT_CYCLES);
    localparam logic [CNT_W-1:0] DASH_CNT   = CNT_W'(2*UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GLITCH_CNT = CNT_W'(UNIT_CYCLES/2);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(2);

    logic                key_s;
    logic                key_prev;
    logic                key_edge;
    logic [CNT_W-1:0]    count;
    state_t              state;
    logic [3:0]          sym;
    logic [2:0]          len;
    logic                ovf;
    lookup_t             lookup;
    logic [LETTER_W-1:0] letter;
    logic                valid;
    logic                error;
    logic                overrun;

    morse_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (bus.key_i),
        .key_sync (key_s)
    );

    assign key_edge = key_s ^ key_prev;
    assign lookup   = morse_lookup(len, sym);

    // The timer counts the edge cycle itself, so a mark seen high for N
    // cycles is classified with count == N.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev <= 1'b0;
            count    <= '0;
        end else begin
            key_prev <= key_s;
            if (key_edge)
                count <= CNT_W'(1);
            else if (count < GAP_CNT)
                count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_REL;
            sym     <= '0;
            len     <= '0;
            ovf     <= 1'b0;
            letter  <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            error   <= 1'b0;
            overrun <= 1'b0;
            if (valid && bus.ready_i)
                valid <= 1'b0;

            case (state)
                // Wait for the synchronizer to flush so a key held through
                // reset is seen high before it is allowed to release.
                WAIT_REL: if (!key_s && count >= SETTLE_CNT) state <= IDLE;
                IDLE:     if (key_s) state <= MARK;
                MARK: begin
                    if (!key_s) begin
                        if (count < GLITCH_CNT) begin
                            state <= (len == 3'd0) ? IDLE : SPACE;
                        end else begin
                            state <= SPACE;
                            if (len == 3'(MAX_SYMS)) begin
                                ovf <= 1'b1;
                            end else begin
                                sym[2'd3 - len[1:0]] <= (count >= DASH_CNT) ? DASH : DOT;
                                len <= len + 3'd1;
                            end
                        end
                    end
                end
                SPACE: begin
                    if (count == GAP_CNT)
                        state <= EMIT;
                    else if (key_s)
                        state <= MARK;
                end
                EMIT: begin
                    if (lookup.valid && !ovf) begin
                        if (!valid || bus.ready_i) begin
                            letter <= lookup.index;
                            valid  <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        error <= 1'b1;
                    end
                    sym   <= '0;
                    len   <= '0;
                    ovf   <= 1'b0;
                    state <= key_s ? MARK : IDLE;
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

    assign bus.letter_o  = letter;
    assign bus.valid_o   = valid;
    assign bus.error_o   = error;
    assign bus.overrun_o = overrun;

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================
// tb_morse_decoder : randomized Morse keying against a table model
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
module tb_morse_decoder;

    localparam int U   = 4;
    localparam int GAP = 3*U;
    localparam int LAT = 3*U + 3;

    typedef struct {
        int kind;    // 0 = letter loaded, 1 = error pulse, 2 = overrun pulse
        int letter;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morse_decoder_if bus ();

    morse_decoder #(.UNIT_CYCLES(U)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string FIXED [3] = '{".-", "....", "--.."};

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_fall = 0;
    int   valid_falls = 0;
    ev_t  evq [$];
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0, prev_ovr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs every handshake load and pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0; prev_ready = 1'b0; prev_err = 1'b0; prev_ovr = 1'b0;
        end else begin
            if (bus.valid_o && (!prev_valid || prev_ready))
                evq.push_back('{0, int'(bus.letter_o), cyc});
            if (bus.error_o)   evq.push_back('{1, 0, cyc});
            if (bus.overrun_o) evq.push_back('{2, 0, cyc});
            if (prev_valid && !bus.valid_o) valid_falls++;
            if (bus.error_o || bus.overrun_o) begin
                checks++;
                if ((bus.error_o && bus.overrun_o) || (bus.error_o && prev_err) ||
                    (bus.overrun_o && prev_ovr)) begin
                    errors++;
                    $display("FAIL pulse_shape: error_o=%b overrun_o=%b (prev %b/%b), required exclusive one-cycle pulses",
                             bus.error_o, bus.overrun_o, prev_err, prev_ovr);
                end
            end
            prev_valid = bus.valid_o; prev_ready = bus.ready_i;
            prev_err   = bus.error_o; prev_ovr   = bus.overrun_o;
        end
    end

    function automatic int ref_decode(input string p);
        for (int i = 0; i < 26; i++)
            if (MORSE[i] == p) return i;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark(input int n);
        bus.key_i = 1'b1;
        tick(n);
        bus.key_i = 1'b0;
        last_fall = cyc + 1;
    endtask

    task automatic send_letter(input string p);
        for (int i = 0; i < p.len(); i++) begin
            if (i > 0) tick($urandom_range(2, 6));
            if (p.getc(i) == "-") mark($urandom_range(8, 14));
            else                  mark($urandom_range(2, 7));
        end
    endtask

    task automatic wait_event(output ev_t e, output bit got);
        got = 1'b0;
        e   = '{-1, -1, -1};
        for (int i = 0; i < LAT + 20 && !got; i++) begin
            if (evq.size() > 0) begin
                e   = evq.pop_front();
                got = 1'b1;
            end else begin
                tick(1);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.key_i = 1'b0; bus.ready_i = 1'b0;
        tick(3);
        checks++;
        if ({bus.letter_o, bus.valid_o, bus.error_o, bus.overrun_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got letter=%0d valid=%b error=%b overrun=%b, required all 0",
                     bus.letter_o, bus.valid_o, bus.error_o, bus.overrun_o);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_letters;
        ev_t e; bit got; int exp; string p;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_letter(FIXED[i]);
            wait_event(e, got);
            exp = ref_decode(FIXED[i]);
            checks++;
            if (!got || e.kind !== 0 || e.letter !== exp) begin
                errors++;
                $display("FAIL letter_%s: got kind=%0d letter=%0d, required kind=0 letter=%0d", FIXED[i], e.kind, e.letter, exp);
            end
            if (i == 0) begin
                checks++;
                if (e.cyc - last_fall !== LAT) begin
                    errors++;
                    $display("FAIL commit_latency: got %0d cycles, required %0d", e.cyc - last_fall, LAT);
                end
            end
            tick(3);
        end
        for (int n = 0; n < 16; n++) begin
            p = "";
            for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                p = {p, ($urandom_range(0, 1) != 0) ? "-" : "."};
            exp = ref_decode(p);
            send_letter(p);
            wait_event(e, got);
            checks++;
            if (exp >= 0 && (!got || e.kind !== 0 || e.letter !== exp)) begin
                errors++;
                $display("FAIL random_%s: got kind=%0d letter=%0d, required kind=0 letter=%0d", p, e.kind, e.letter, exp);
            end else if (exp < 0 && (!got || e.kind !== 1 || bus.valid_o !== 1'b0)) begin
                errors++;
                $display("FAIL random_%s: got kind=%0d valid=%b, required kind=1 (error) valid=0", p, e.kind, bus.valid_o);
            end
            tick($urandom_range(1, 4));
        end
    endtask

    task automatic test_errors;
        ev_t e; bit got;
        bus.ready_i = 1'b1;
        send_letter("..--");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL no_match: got kind=%0d valid=%b, required kind=1 valid=0", e.kind, bus.valid_o);
        end
        tick(3);
        send_letter(".....");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 1) begin
            errors++;
            $display("FAIL five_symbols: got kind=%0d, required kind=1", e.kind);
        end
        tick(3);
        send_letter("-");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== ref_decode("-")) begin
            errors++;
            $display("FAIL after_overflow: got kind=%0d letter=%0d, required kind=0 letter=%0d", e.kind, e.letter, ref_decode("-"));
        end
        tick(3);
    endtask

    task automatic test_overrun;
        ev_t e; bit got;
        bus.ready_i = 1'b0;
        send_letter(".");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== ref_decode(".")) begin
            errors++;
            $display("FAIL held_first: got kind=%0d letter=%0d, required kind=0 letter=%0d", e.kind, e.letter, ref_decode("."));
        end
        send_letter("-");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 2) begin
            errors++;
            $display("FAIL overrun_pulse: got kind=%0d, required kind=2", e.kind);
        end
        tick(5);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.letter_o !== 5'(ref_decode("."))) begin
            errors++;
            $display("FAIL held_after_overrun: got valid=%b letter=%0d, required valid=1 letter=%0d", bus.valid_o, bus.letter_o, ref_decode("."));
        end
        bus.ready_i = 1'b1;
        tick(1);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL consume: got valid=%b, required 0", bus.valid_o);
        end
        tick(3);
    endtask

    task automatic test_back_to_back;
        ev_t e; bit got; int vf; int idx; int exp;
        bus.ready_i = 1'b0;
        send_letter("--");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== ref_decode("--")) begin
            errors++;
            $display("FAIL b2b_first: got kind=%0d letter=%0d, required kind=0 letter=%0d", e.kind, e.letter, ref_decode("--"));
        end
        tick(2);
        vf  = valid_falls;
        idx = $urandom_range(0, 25);
        exp = ref_decode(MORSE[idx]);
        send_letter(MORSE[idx]);
        tick(LAT);
        bus.ready_i = 1'b1;
        tick(1);
        bus.ready_i = 1'b0;
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== exp || e.cyc !== last_fall + LAT) begin
            errors++;
            $display("FAIL b2b_second: got kind=%0d letter=%0d cyc=%0d, required kind=0 letter=%0d cyc=%0d",
                     e.kind, e.letter, e.cyc, exp, last_fall + LAT);
        end
        tick(4);
        checks++;
        if (valid_falls !== vf || evq.size() !== 0 || bus.valid_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_continuity: got valid drops=%0d extra events=%0d valid=%b, required 0 drops, 0 events, valid=1",
                     valid_falls - vf, evq.size(), bus.valid_o);
        end
        bus.ready_i = 1'b1;
        tick(3);
    endtask

    task automatic test_glitch;
        ev_t e; bit got; int lens [4] = '{7, 8, 2, 30}; int exp;
        bus.ready_i = 1'b1;
        mark(1);
        tick(GAP + 10);
        checks++;
        if (evq.size() !== 0) begin
            errors++;
            $display("FAIL idle_glitch: got %0d events, required 0", evq.size());
            evq.delete();
        end
        mark(5); tick(3); mark(1); tick(3); mark(10);
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== ref_decode(".-")) begin
            errors++;
            $display("FAIL mid_glitch: got kind=%0d letter=%0d, required kind=0 letter=%0d", e.kind, e.letter, ref_decode(".-"));
        end
        tick(3);
        for (int i = 0; i < 4; i++) begin
            exp = ref_decode((lens[i] >= 2*U) ? "-" : ".");
            mark(lens[i]);
            wait_event(e, got);
            checks++;
            if (!got || e.kind !== 0 || e.letter !== exp) begin
                errors++;
                $display("FAIL mark_len_%0d: got kind=%0d letter=%0d, required kind=0 letter=%0d", lens[i], e.kind, e.letter, exp);
            end
            tick(3);
        end
    endtask

    task automatic test_reset_held;
        ev_t e; bit got;
        bus.ready_i = 1'b1;
        rst = 1'b1; bus.key_i = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        bus.key_i = 1'b0;
        tick(GAP + 10);
        checks++;
        if (evq.size() !== 0) begin
            errors++;
            $display("FAIL held_through_reset: got %0d events, required 0", evq.size());
            evq.delete();
        end
        send_letter(".-");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== ref_decode(".-")) begin
            errors++;
            $display("FAIL after_held_release: got kind=%0d letter=%0d, required kind=0 letter=%0d", e.kind, e.letter, ref_decode(".-"));
        end
        bus.ready_i = 1'b0;
        tick(3);
        send_letter(".");
        wait_event(e, got);
        send_letter("-");
        tick(2);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({bus.letter_o, bus.valid_o, bus.error_o, bus.overrun_o} !== 8'h00) begin
            errors++;
            $display("FAIL mid_letter_reset: got letter=%0d valid=%b error=%b overrun=%b, required all 0",
                     bus.letter_o, bus.valid_o, bus.error_o, bus.overrun_o);
        end
        tick(2);
        evq.delete();
        rst = 1'b0;
        tick(GAP + 10);
        checks++;
        if (evq.size() !== 0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL partial_lost: got %0d events valid=%b, required 0 events valid=0", evq.size(), bus.valid_o);
        end
        bus.ready_i = 1'b1;
        send_letter("-");
        wait_event(e, got);
        checks++;
        if (!got || e.kind !== 0 || e.letter !== ref_decode("-")) begin
            errors++;
            $display("FAIL recover: got kind=%0d letter=%0d, required kind=0 letter=%0d", e.kind, e.letter, ref_decode("-"));
        end
    endtask

    initial begin
        bus.key_i   = 1'b0;
        bus.ready_i = 1'b0;
        test_reset();
        test_letters();
        test_errors();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_reset_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
